// File: rtl/pa_idu_reg_sbd_pkg.sv
// Shared type encoding and index widths for the IDU register scoreboard.
package pa_idu_sbd_pkg;

    typedef enum logic {
        SBD_ALU = 1'b0,
        SBD_LSU = 1'b1
    } sbd_typ_e;

    localparam int unsigned SBD_REG_NUM = 16;
    localparam int unsigned IDX_W       = $clog2(SBD_REG_NUM);

    function automatic int unsigned sbd_idx_w(input int unsigned reg_num);
        return (reg_num < 2) ? 1 : $clog2(reg_num);
    endfunction

endpackage

// File: rtl/pa_idu_reg_sbd_if.sv
// Issue, interrupt-clear, writeback and read-port bundle of the register scoreboard.
interface pa_idu_reg_sbd_if
    import pa_idu_sbd_pkg::*;
#(
    parameter int IW        = IDX_W,
    parameter int REG_WIDTH = 32
);
    logic                 iss_vld;
    logic [IW-1:0]        iss_idx;
    logic                 iss_ld;
    logic                 iss_stall_req;
    logic                 iss_full;
    logic                 int_clr_vld;
    logic [IW-1:0]        int_clr_idx;
    logic                 alu_wb_vld;
    logic [IW-1:0]        alu_wb_idx;
    logic [REG_WIDTH-1:0] alu_wb_data;
    logic                 lsu_wb_vld;
    logic [IW-1:0]        lsu_wb_idx;
    logic [REG_WIDTH-1:0] lsu_wb_data;
    logic [IW-1:0]        rd0_idx;
    logic [IW-1:0]        rd1_idx;
    logic [REG_WIDTH-1:0] rd0_data;
    logic [REG_WIDTH-1:0] rd1_data;
    logic                 rd0_busy;
    logic                 rd1_busy;
    logic                 rd0_busy_lsu;
    logic                 rd1_busy_lsu;

    modport master (
        output iss_vld, iss_idx, iss_ld, iss_stall_req,
        output int_clr_vld, int_clr_idx,
        output alu_wb_vld, alu_wb_idx, alu_wb_data,
        output lsu_wb_vld, lsu_wb_idx, lsu_wb_data,
        output rd0_idx, rd1_idx,
        input  iss_full, rd0_data, rd1_data,
        input  rd0_busy, rd1_busy, rd0_busy_lsu, rd1_busy_lsu
    );

    modport slave (
        input  iss_vld, iss_idx, iss_ld, iss_stall_req,
        input  int_clr_vld, int_clr_idx,
        input  alu_wb_vld, alu_wb_idx, alu_wb_data,
        input  lsu_wb_vld, lsu_wb_idx, lsu_wb_data,
        input  rd0_idx, rd1_idx,
        output iss_full, rd0_data, rd1_data,
        output rd0_busy, rd1_busy, rd0_busy_lsu, rd1_busy_lsu
    );
endinterface

// File: rtl/gated_clk_cell.sv
// Latch-based clock gate: enable is captured while the clock is low so the gated clock never glitches.
module gated_clk_cell (
    input  logic clk_in,
    input  logic local_en,
    output logic clk_out
);
    logic en_lat;

    always_latch begin
        if (!clk_in) en_lat <= local_en;
    end

    assign clk_out = clk_in & en_lat;
endmodule

// File: rtl/pa_idu_sbd_entry.sv
// One scoreboard entry: in-order producer type FIFO, producer count, gated data register and stall flags.
module pa_idu_sbd_entry
    import pa_idu_sbd_pkg::*;
#(
    parameter int REG_WIDTH = 32,
    parameter int DEPTH     = 2
)(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 warm_up,
    input  logic                 flush,
    input  logic                 push,
    input  logic                 push_ld,
    input  logic                 alu_hit,
    input  logic                 lsu_hit,
    input  logic                 clr_hit,
    input  logic [REG_WIDTH-1:0] alu_data,
    input  logic [REG_WIDTH-1:0] lsu_data,
    output logic [REG_WIDTH-1:0] data,
    output logic                 full,
    output logic                 busy,
    output logic                 busy_lsu
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nxt;
    logic [DEPTH-1:0] typ;
    logic [DEPTH-1:0] typ_nxt;
    logic [DEPTH-1:0] lsu_vis;
    sbd_typ_e         head;
    logic             nonempty;
    logic             alu_pop;
    logic             lsu_pop;
    logic             pop;
    logic             push_ok;
    logic             gclk;

    assign head     = sbd_typ_e'(typ[0]);
    assign nonempty = (cnt != '0);
    assign alu_pop  = alu_hit & nonempty & (head == SBD_ALU);
    assign lsu_pop  = lsu_hit & nonempty & (head == SBD_LSU);
    assign pop      = alu_pop | lsu_pop | (clr_hit & nonempty);
    assign full     = (cnt == CW'(DEPTH)) & ~pop;
    assign push_ok  = push & ~full;
    assign busy     = nonempty & (head == SBD_ALU) & ~alu_pop;

    // A retiring LSU head is masked out so dependants can issue in the writeback cycle.
    always_comb begin
        lsu_vis = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < cnt) lsu_vis[i] = typ[i];
        end
        if (lsu_pop) lsu_vis[0] = 1'b0;
    end
    assign busy_lsu = |lsu_vis;

    always_comb begin
        typ_nxt = typ;
        cnt_nxt = cnt;
        if (pop) begin
            typ_nxt = typ >> 1;
            cnt_nxt = cnt - CW'(1);
        end
        if (push_ok) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (CW'(i) == cnt_nxt) typ_nxt[i] = push_ld;
            end
            cnt_nxt = cnt_nxt + CW'(1);
        end
        if (flush) begin
            typ_nxt = '0;
            cnt_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            typ <= '0;
        end else begin
            cnt <= cnt_nxt;
            typ <= typ_nxt;
        end
    end

    gated_clk_cell x_gclk (
        .clk_in   (clk),
        .local_en (alu_hit | lsu_hit | warm_up),
        .clk_out  (gclk)
    );

    always_ff @(posedge gclk) begin
        if (warm_up)      data <= '0;
        else if (lsu_hit) data <= lsu_data;
        else              data <= alu_data;
    end
endmodule

// File: rtl/pa_idu_reg_sbd.sv
// IDU register bank with per-entry write scoreboard; decodes indices onto the entries and muxes the read ports.
module pa_idu_reg_sbd
    import pa_idu_sbd_pkg::*;
#(
    parameter int REG_NUM   = 16,
    parameter int REG_WIDTH = 32,
    parameter int DEPTH     = 2,
    parameter int ZERO_REG0 = 0
)(
    input  logic              forever_cpuclk,
    input  logic              cpurst_b,
    input  logic              ifu_idu_warm_up,
    input  logic              rtu_idu_flush_fe,
    pa_idu_reg_sbd_if.slave   sbd
);
    localparam int IW = sbd_idx_w(REG_NUM);

    logic [REG_WIDTH-1:0] ent_data [REG_NUM];
    logic [REG_NUM-1:0]   ent_full;
    logic [REG_NUM-1:0]   ent_busy;
    logic [REG_NUM-1:0]   ent_busy_lsu;
    logic                 iss_push;

    assign iss_push = sbd.iss_vld & ~sbd.iss_stall_req;

    for (genvar g = 0; g < REG_NUM; g++) begin : g_ent
        if ((ZERO_REG0 != 0) && (g == 0)) begin : g_zero
            assign ent_data[g]     = '0;
            assign ent_full[g]     = 1'b0;
            assign ent_busy[g]     = 1'b0;
            assign ent_busy_lsu[g] = 1'b0;
        end else begin : g_live
            pa_idu_sbd_entry #(
                .REG_WIDTH (REG_WIDTH),
                .DEPTH     (DEPTH)
            ) x_ent (
                .clk      (forever_cpuclk),
                .rst_n    (cpurst_b),
                .warm_up  (ifu_idu_warm_up),
                .flush    (rtu_idu_flush_fe),
                .push     (iss_push & (sbd.iss_idx == IW'(g))),
                .push_ld  (sbd.iss_ld),
                .alu_hit  (sbd.alu_wb_vld & (sbd.alu_wb_idx == IW'(g))),
                .lsu_hit  (sbd.lsu_wb_vld & (sbd.lsu_wb_idx == IW'(g))),
                .clr_hit  (sbd.int_clr_vld & (sbd.int_clr_idx == IW'(g))),
                .alu_data (sbd.alu_wb_data),
                .lsu_data (sbd.lsu_wb_data),
                .data     (ent_data[g]),
                .full     (ent_full[g]),
                .busy     (ent_busy[g]),
                .busy_lsu (ent_busy_lsu[g])
            );
        end
    end

    assign sbd.iss_full     = ent_full[sbd.iss_idx];
    assign sbd.rd0_data     = ent_data[sbd.rd0_idx];
    assign sbd.rd1_data     = ent_data[sbd.rd1_idx];
    assign sbd.rd0_busy     = ent_busy[sbd.rd0_idx];
    assign sbd.rd1_busy     = ent_busy[sbd.rd1_idx];
    assign sbd.rd0_busy_lsu = ent_busy_lsu[sbd.rd0_idx];
    assign sbd.rd1_busy_lsu = ent_busy_lsu[sbd.rd1_idx];

    // Issuing into a full entry is a protocol error from decode; the push is silently dropped.
    a_no_push_full: assert property (@(posedge forever_cpuclk) disable iff (!cpurst_b)
        !(iss_push && sbd.iss_full));
endmodule

// File: tb/tb_pa_idu_reg_sbd.sv
// Directed scoreboard bench for pa_idu_reg_sbd (REG_NUM=16, DEPTH=2).
module tb_pa_idu_reg_sbd;
    import pa_idu_sbd_pkg::*;

    logic clk     = 1'b0;
    logic rst_b   = 1'b0;
    logic warm_up = 1'b0;
    logic flush   = 1'b0;

    always #5 clk = ~clk;

    pa_idu_reg_sbd_if #(.IW(IDX_W), .REG_WIDTH(32)) bus ();

    pa_idu_reg_sbd #(
        .REG_NUM   (16),
        .REG_WIDTH (32),
        .DEPTH     (2),
        .ZERO_REG0 (0)
    ) dut (
        .forever_cpuclk   (clk),
        .cpurst_b         (rst_b),
        .ifu_idu_warm_up  (warm_up),
        .rtu_idu_flush_fe (flush),
        .sbd              (bus)
    );

    typedef enum int {S_RD0_DATA, S_RD1_DATA, S_RD0_BUSY, S_RD1_BUSY,
                      S_RD0_LSU, S_RD1_LSU, S_FULL} sig_e;
    typedef struct {
        string       nm;
        sig_e        sig;
        logic [31:0] val;
        int          cyc;
    } exp_t;

    exp_t sbq[$];
    int   cyc   = 0;
    int   n_chk = 0;
    int   n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] sample(sig_e s);
        case (s)
            S_RD0_DATA: return bus.rd0_data;
            S_RD1_DATA: return bus.rd1_data;
            S_RD0_BUSY: return 32'(bus.rd0_busy);
            S_RD1_BUSY: return 32'(bus.rd1_busy);
            S_RD0_LSU:  return 32'(bus.rd0_busy_lsu);
            S_RD1_LSU:  return 32'(bus.rd1_busy_lsu);
            default:    return 32'(bus.iss_full);
        endcase
    endfunction

    function automatic void chk(string nm, sig_e s, logic [31:0] v);
        sbq.push_back('{nm, s, v, cyc});
    endfunction

    // Monitor: pops every expectation due this cycle and compares mid-cycle.
    initial begin
        exp_t        e;
        logic [31:0] act;
        forever begin
            @(negedge clk);
            #3;
            while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
                e   = sbq.pop_front();
                act = sample(e.sig);
                n_chk++;
                if (act !== e.val) begin
                    n_err++;
                    $display("FAIL %s cyc=%0d actual=%h required=%h", e.nm, e.cyc, act, e.val);
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
        warm_up           = 1'b0;
        flush             = 1'b0;
        bus.iss_vld       = 1'b0;
        bus.iss_ld        = 1'b0;
        bus.iss_stall_req = 1'b0;
        bus.int_clr_vld   = 1'b0;
        bus.alu_wb_vld    = 1'b0;
        bus.lsu_wb_vld    = 1'b0;
    endtask

    task automatic issue(input logic [3:0] idx, input logic ld);
        bus.iss_vld = 1'b1;
        bus.iss_idx = idx;
        bus.iss_ld  = ld;
    endtask

    task automatic alu_wb(input logic [3:0] idx, input logic [31:0] d);
        bus.alu_wb_vld  = 1'b1;
        bus.alu_wb_idx  = idx;
        bus.alu_wb_data = d;
    endtask

    task automatic lsu_wb(input logic [3:0] idx, input logic [31:0] d);
        bus.lsu_wb_vld  = 1'b1;
        bus.lsu_wb_idx  = idx;
        bus.lsu_wb_data = d;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout cyc=%0d required=finish", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        bus.iss_vld = 0; bus.iss_idx = 0; bus.iss_ld = 0; bus.iss_stall_req = 0;
        bus.int_clr_vld = 0; bus.int_clr_idx = 0;
        bus.alu_wb_vld = 0; bus.alu_wb_idx = 0; bus.alu_wb_data = 0;
        bus.lsu_wb_vld = 0; bus.lsu_wb_idx = 0; bus.lsu_wb_data = 0;
        bus.rd0_idx = 0; bus.rd1_idx = 0;

        step();
        chk("rst_busy", S_RD0_BUSY, 0); chk("rst_lsu", S_RD1_LSU, 0); chk("rst_full", S_FULL, 0);
        rst_b = 1'b1;
        step(); warm_up = 1'b1;

        step(); bus.rd0_idx = 3; bus.rd1_idx = 15; issue(3, 0);
        chk("wu_rd0", S_RD0_DATA, 0); chk("wu_rd1", S_RD1_DATA, 0);
        chk("wu_busy", S_RD0_BUSY, 0); chk("wu_lsu", S_RD1_LSU, 0); chk("wu_full", S_FULL, 0);
        step(); chk("alu_busy", S_RD0_BUSY, 1);
        step(); alu_wb(3, 32'hDEAD_BEEF);
        chk("wb_busy_fwd", S_RD0_BUSY, 0); chk("wb_data_old", S_RD0_DATA, 0);
        step(); chk("wb_data", S_RD0_DATA, 32'hDEAD_BEEF); chk("wb_busy", S_RD0_BUSY, 0);

        step(); issue(5, 1);
        step(); issue(5, 1); bus.rd0_idx = 5;
        chk("ld_lsu1", S_RD0_LSU, 1); chk("ld_full1", S_FULL, 0); chk("ld_busy", S_RD0_BUSY, 0);
        step(); chk("ld_full2", S_FULL, 1); chk("ld_lsu2", S_RD0_LSU, 1);
        step(); lsu_wb(5, 32'h11);
        chk("ld_pop1_lsu", S_RD0_LSU, 1); chk("ld_pop1_full", S_FULL, 0);
        step(); lsu_wb(5, 32'h22);
        chk("ld_pop2_lsu", S_RD0_LSU, 0); chk("ld_data1", S_RD0_DATA, 32'h11);
        step(); chk("ld_data2", S_RD0_DATA, 32'h22); chk("ld_empty_full", S_FULL, 0);
        chk("ld_empty_lsu", S_RD0_LSU, 0);

        step(); issue(6, 1); bus.iss_stall_req = 1'b1;
        step(); bus.rd1_idx = 6; issue(7, 1);
        chk("stall_lsu", S_RD1_LSU, 0); chk("stall_busy", S_RD1_BUSY, 0);
        step(); issue(7, 0);
        step(); alu_wb(7, 32'h77); bus.rd0_idx = 7;
        chk("mm_busy", S_RD0_BUSY, 0); chk("mm_lsu", S_RD0_LSU, 1); chk("mm_full", S_FULL, 1);
        step(); lsu_wb(7, 32'h78);
        chk("mm_data", S_RD0_DATA, 32'h77); chk("mm_busy2", S_RD0_BUSY, 0);
        chk("mm_lsu_pop", S_RD0_LSU, 0); chk("mm_full_pop", S_FULL, 0);
        step(); chk("mm_alu_busy", S_RD0_BUSY, 1); chk("mm_lsu3", S_RD0_LSU, 0);
        chk("mm_data2", S_RD0_DATA, 32'h78);
        step(); alu_wb(7, 32'h79); chk("mm_alu_fwd", S_RD0_BUSY, 0);
        step(); chk("mm_data3", S_RD0_DATA, 32'h79);

        step(); issue(2, 0);
        step(); issue(2, 0);
        step(); issue(2, 0); bus.int_clr_vld = 1'b1; bus.int_clr_idx = 2;
        alu_wb(4, 32'h1); lsu_wb(4, 32'h2);
        chk("pp_full", S_FULL, 0);
        step(); bus.rd0_idx = 4; bus.iss_idx = 2; bus.rd1_idx = 2;
        chk("dual_wb", S_RD0_DATA, 32'h2); chk("pp_full2", S_FULL, 1); chk("pp_busy", S_RD1_BUSY, 1);

        step(); issue(1, 0);
        step(); issue(9, 1);
        step(); bus.rd0_idx = 1; bus.rd1_idx = 9;
        chk("fl_b1", S_RD0_BUSY, 1); chk("fl_l9", S_RD1_LSU, 1);
        step(); flush = 1'b1; issue(1, 0); bus.rd0_idx = 2;
        chk("fl_pre", S_RD0_BUSY, 1);
        step(); bus.rd0_idx = 1; bus.iss_idx = 2;
        chk("fl_b1_clr", S_RD0_BUSY, 0); chk("fl_l9_clr", S_RD1_LSU, 0); chk("fl_full2", S_FULL, 0);
        step(); bus.rd0_idx = 2; chk("fl_b2_clr", S_RD0_BUSY, 0);

        step(); issue(3, 0);
        step(); bus.rd0_idx = 3; bus.rd1_idx = 3; chk("ar_pre", S_RD0_BUSY, 1);
        step(); rst_b = 1'b0;
        chk("ar_busy", S_RD0_BUSY, 0); chk("ar_busy1", S_RD1_BUSY, 0);
        step(); rst_b = 1'b1;
        chk("ar_data_kept", S_RD0_DATA, 32'hDEAD_BEEF); chk("ar_busy2", S_RD0_BUSY, 0);

        repeat (3) step();
        n_chk++;
        if (sbq.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain pending=%0d required=0", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/pa_idu_reg_sbd.md
Name: pa_idu_reg_sbd

Overview:
- Parametrised register bank with a per-entry write-scoreboard.
- Replaces single-entry register plus 3-bit busy FSM instances.
- Each entry tracks up to DEPTH in-flight producers in issue order, typed ALU or LSU.
- Sits in IDU between decode/issue and RTU writeback. Exposes register data plus ALU-busy and LSU-busy per read port for RAW/WAW stall generation.

Parameters:
REG_NUM, 16, number of entries (power of 2, >=2)
REG_WIDTH, 32, data width per entry
DEPTH, 2, max outstanding producers per entry (1..4)
ZERO_REG0, 0, 1: entry 0 reads zero, never busy, ignores writes and issues

Ports:
forever_cpuclk  in  1  core clock
cpurst_b  in  1  async active-low reset
ifu_idu_warm_up  in  1  zero all data entries
rtu_idu_flush_fe  in  1  clear all scoreboard state
iss_vld  in  1  instruction issued that writes iss_idx
iss_idx  in  log2(REG_NUM)  issue destination
iss_ld  in  1  producer is LSU load
iss_stall_req  in  1  suppress issue push (int-disable stall)
iss_full  out  1  entry iss_idx is full and not popping this cycle
int_clr_vld  in  1  interrupt-clear: pop head of int_clr_idx
int_clr_idx  in  log2(REG_NUM)  entry to clear
alu_wb_vld  in  1  ALU writeback
alu_wb_idx  in  log2(REG_NUM)  ALU writeback entry
alu_wb_data  in  REG_WIDTH  ALU writeback data
lsu_wb_vld  in  1  LSU writeback
lsu_wb_idx  in  log2(REG_NUM)  LSU writeback entry
lsu_wb_data  in  REG_WIDTH  LSU writeback data
rd0_idx, rd1_idx  in  log2(REG_NUM)  read indices
rd0_data, rd1_data  out  REG_WIDTH  entry data (no bypass)
rd0_busy, rd1_busy  out  1  head producer is ALU, not retiring this cycle
rd0_busy_lsu, rd1_busy_lsu  out  1  any LSU producer outstanding, not fully retiring this cycle

Behaviour:
- Clocking: one clock, forever_cpuclk. Reset asynchronous, active-low, cpurst_b.
- State per entry:
  - cnt[0..DEPTH]
  - typ[DEPTH-1:0] FIFO of type bits, bit0 = head (oldest); 1 = LSU
  - data[REG_WIDTH]
- Reset: all cnt = 0, typ = 0. Data has no reset. All busy outputs 0 after reset. Data is undefined until warm-up or a write.
- Data write, registered, visible on rd*_data the next cycle:
  - ifu_idu_warm_up: all entries <= 0; overrides writebacks.
  - Otherwise alu_wb and lsu_wb each write their entry.
  - Same idx both valid: LSU data wins.
  - Per-entry clock gating uses gated_clk_cell, local_en = any write to that entry | warm_up.
- Push: iss_vld & ~iss_stall_req & ~iss_full.
  - Appends iss_ld at position cnt (after any pop this cycle).
  - cnt++.
- Pop: at most one per entry per cycle. Head is removed when any of these hit the entry:
  - alu_wb hits entry and head is ALU
  - lsu_wb hits entry and head is LSU
  - int_clr hits entry (any head type)
  - Pop shifts typ right by 1 and decrements cnt.
  - A writeback whose type mismatches the head writes data but does not pop.
  - Pop on cnt == 0 is ignored.
- Simultaneous events:
  - Push and pop on the same entry: cnt unchanged, FIFO shifts, then appends.
  - iss_full = (cnt == DEPTH) & ~pop_this_cycle(iss_idx).
  - Push while iss_full is dropped; this is a protocol error, flagged by an assertion.
- Flush: rtu_idu_flush_fe forces all cnt = 0 next cycle. Overrides same-cycle pushes and pops. Data writes still occur.
- Busy flags, combinational from current state plus same-cycle pops (forwarding-safe):
  - busy = cnt > 0 & head == ALU & ~(ALU pop on this entry this cycle).
  - busy_lsu = any valid typ bit == LSU, after removing the entry's same-cycle LSU pop.
- ZERO_REG0 = 1: idx 0 reads data 0, all flags 0, iss_full 0.
- Issue index out of range cannot occur (REG_NUM is a power of 2).

Decomposition:
- Shared package pa_idu_sbd_pkg holds:
  - type encoding (SBD_ALU = 0, SBD_LSU = 1)
  - IDX_W = log2(REG_NUM)
- Natural sub-module pa_idu_sbd_entry: one entry's cnt/typ FIFO, data, gated clock and flag generation. Instantiated REG_NUM times via generate.
- Top level does index decode and read muxing.

Test Plan:
- Reset, then warm_up one cycle → all rd*_data = 0, all busy flags 0, iss_full 0.
- Issue ALU to idx 3 → rd0_idx = 3 gives busy = 1. Next cycle alu_wb idx 3, data 0xDEAD_BEEF → busy = 0 that same cycle. Following cycle rd0_data = 0xDEADBEEF.
- DEPTH = 2: issue LD, then LD to idx 5 → iss_full = 1.
  - Third issue is dropped; cnt stays 2.
  - lsu_wb idx 5 → busy_lsu stays 1, iss_full = 0 that cycle.
  - Second lsu_wb → busy_lsu = 0.
- Entry 7 holds [LSU, ALU]: alu_wb idx 7 → data written, no pop, busy_lsu = 1. lsu_wb pops, then busy = 1 until alu_wb.
- Same cycle: issue ALU to idx 2 plus int_clr idx 2 with cnt = 2 (full) → accepted, cnt stays 2. Same cycle, alu_wb and lsu_wb to idx 4 with 0x1 / 0x2 → rd_data = 0x2.
- Entries 1, 2, 9 busy; assert rtu_idu_flush_fe with a concurrent issue to idx 1 → next cycle all flags 0. Reassert cpurst_b low mid-operation → flags clear asynchronously.
